wb_write_arbiter: RTL and testbench

Writeback-side driver of the integer register file write port in the 64-bit pipelined core. It registers the MEM/WB result (ALU result or load data) and drives the register file's single write port. It also accepts results from the long-latency unit (mul/div) through a small FIFO and fills idle writeback slots with them. A pending-destination scoreboard is exported to hazard detection so consumers of in-flight long-latency results stall.

---
 rtl/wb_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_write_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Purpose: writeback driver of the integer regfile write port; merges MEM/WB results
//          with buffered long-latency (mul/div) results and tracks pending ll writes.
// Latency: pipeline result 1 cycle; ll result >= 2 cycles (push edge, then pop edge).
// Backpressure: pipeline never stalls; ll side stalls via ll_ready when the FIFO is full.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   wb_valid/wb_reg_write/wb_rd     MEM/WB slot qualification and destination
//   wb_mem_to_reg, wb_alu_result,
//   wb_mem_data                     result select and candidate write data
//   ll_issue_valid/ll_issue_rd      long-latency issue, marks rd pending
//   ll_valid/ll_rd/ll_data/ll_ready long-latency result handshake into the FIFO
//   rf_we/rf_rd/rf_wdata            registered regfile write port
//   pend_mask                       registered per-register pending ll write mask

// Small synchronous FIFO: push/pop may coincide; no bypass from push to read head.
module wb_ll_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
endmodule

module wb_write_arbiter #(
  parameter int XLEN     = 64,
  parameter int LL_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_reg_write,
  input  logic            wb_mem_to_reg,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [XLEN-1:0] wb_mem_data,
  input  logic            ll_issue_valid,
  input  logic [4:0]      ll_issue_rd,
  input  logic            ll_valid,
  input  logic [4:0]      ll_rd,
  input  logic [XLEN-1:0] ll_data,
  output logic            ll_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     pend_mask
);
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ll_entry_t;

  ll_entry_t push_ent;
  ll_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pipe_hit;
  logic      push;
  logic      pop;
  logic [31:0] pend_set;
  logic [31:0] pend_clr;

  // Writes to x0 are architecturally void: drop them so the slot can drain the FIFO.
  assign pipe_hit = wb_valid && wb_reg_write && (wb_rd != 5'd0);

  assign ll_ready = !reset && !fifo_full;
  // An x0 ll result still completes its handshake but is never buffered.
  assign push     = ll_valid && ll_ready && (ll_rd != 5'd0);
  // Long-latency results only take slots the pipeline leaves idle.
  assign pop      = !pipe_hit && !fifo_empty;

  assign push_ent.rd   = ll_rd;
  assign push_ent.data = ll_data;

  wb_ll_fifo #(
    .WIDTH ($bits(ll_entry_t)),
    .DEPTH (LL_DEPTH)
  ) u_ll_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_ent),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= '0;
    end else if (pipe_hit) begin
      rf_we    <= 1'b1;
      rf_rd    <= wb_rd;
      rf_wdata <= wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_rd    <= head.rd;
      rf_wdata <= head.data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Set is applied after clear so a re-issue to the register being retired stays pending.
  assign pend_set = (ll_issue_valid && (ll_issue_rd != 5'd0)) ? (32'd1 << ll_issue_rd) : 32'd0;
  assign pend_clr = pop ? (32'd1 << head.rd) : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) pend_mask <= 32'd0;
    else       pend_mask <= (pend_mask & ~pend_clr) | pend_set;
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic [63:0] wb_alu_result, wb_mem_data;
  logic        ll_issue_valid;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [63:0] ll_data;
  logic        ll_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;
  logic [31:0] pend_mask;

  int checks = 0;
  int failures = 0;

  wb_write_arbiter #(.XLEN(64), .LL_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_mem_to_reg  (wb_mem_to_reg),
    .wb_rd          (wb_rd),
    .wb_alu_result  (wb_alu_result),
    .wb_mem_data    (wb_mem_data),
    .ll_issue_valid (ll_issue_valid),
    .ll_issue_rd    (ll_issue_rd),
    .ll_valid       (ll_valid),
    .ll_rd          (ll_rd),
    .ll_data        (ll_data),
    .ll_ready       (ll_ready),
    .rf_we          (rf_we),
    .rf_rd          (rf_rd),
    .rf_wdata       (rf_wdata),
    .pend_mask      (pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, w, m;
    logic [4:0]  rd;
    logic [63:0] alu, mem;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [63:0] e_wd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_reg_write = 0; wb_mem_to_reg = 0; wb_rd = 0;
    wb_alu_result = 0; wb_mem_data = 0;
    ll_issue_valid = 0; ll_issue_rd = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [63:0] val);
    wb_valid = 1; wb_reg_write = 1; wb_mem_to_reg = 0; wb_rd = rd; wb_alu_result = val;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [63:0] val);
    ll_valid = 1; ll_rd = rd; ll_data = val;
  endtask

  task automatic chk_rf(input string name, input logic we, input logic [4:0] rd, input logic [63:0] wd);
    chk({name, "_we"}, 64'(rf_we), 64'(we));
    if (we) begin
      chk({name, "_rd"}, 64'(rf_rd), 64'(rd));
      chk({name, "_wdata"}, rf_wdata, wd);
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd5,  64'h1234, 64'h0, 1'b1, 5'd5, 64'h1234};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd5,  64'h9999, 64'hDEAD, 1'b1, 5'd5, 64'hDEAD};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd0,  64'hFFFF, 64'h0, 1'b0, 5'd5, 64'hDEAD};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd3,  64'h77, 64'h0, 1'b0, 5'd5, 64'hDEAD};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd3,  64'h77, 64'h0, 1'b0, 5'd5, 64'hDEAD};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 5'd1,  64'h5555, 64'h0123_4567_89AB_CDEF, 1'b1, 5'd1, 64'h0123_4567_89AB_CDEF};

    // Reset state
    idle();
    reset = 1;
    step();
    step();
    chk("rst_ll_ready", 64'(ll_ready), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_rd", 64'(rf_rd), 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    reset = 0;
    #1;
    chk("post_rst_ll_ready", 64'(ll_ready), 64'd1);

    // Table-driven pipeline writes; rf_rd/rf_wdata hold when rf_we=0.
    for (int i = 0; i < 7; i++) begin
      wb_valid = vecs[i].v; wb_reg_write = vecs[i].w; wb_mem_to_reg = vecs[i].m;
      wb_rd = vecs[i].rd; wb_alu_result = vecs[i].alu; wb_mem_data = vecs[i].mem;
      step();
      chk($sformatf("vec%0d_we", i), 64'(rf_we), 64'(vecs[i].e_we));
      chk($sformatf("vec%0d_rd", i), 64'(rf_rd), 64'(vecs[i].e_rd));
      chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].e_wd);
    end
    idle();

    // ll result to x0: handshake completes, nothing is ever written.
    offer(5'd0, 64'h55);
    #1;
    chk("x0_ll_ready", 64'(ll_ready), 64'd1);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("x0_no_write%0d", i), 64'(rf_we), 64'd0);
    end

    // Contention: ll result waits behind 3 pipe writes.
    ll_issue_valid = 1; ll_issue_rd = 5'd7;
    step();
    ll_issue_valid = 0;
    chk("cont_pend_set", 64'(pend_mask), 64'h80);
    pipe(5'd1, 64'h11); offer(5'd7, 64'hAA);
    step();
    ll_valid = 0;
    chk_rf("cont_p1", 1'b1, 5'd1, 64'h11);
    pipe(5'd2, 64'h22);
    step();
    chk_rf("cont_p2", 1'b1, 5'd2, 64'h22);
    chk("cont_pend_mid", 64'(pend_mask), 64'h80);
    pipe(5'd3, 64'h33);
    step();
    chk_rf("cont_p3", 1'b1, 5'd3, 64'h33);
    chk("cont_pend_p3", 64'(pend_mask), 64'h80);
    idle();
    step();
    chk_rf("cont_ll", 1'b1, 5'd7, 64'hAA);
    chk("cont_pend_clr", 64'(pend_mask), 64'h0);
    step();
    chk("cont_idle_we", 64'(rf_we), 64'd0);

    // FIFO full: third offer held until a slot frees.
    pipe(5'd1, 64'h101); offer(5'd8, 64'h88);
    #1;
    chk("full_rdy0", 64'(ll_ready), 64'd1);
    step();
    pipe(5'd2, 64'h102); offer(5'd9, 64'h99);
    #1;
    chk("full_rdy1", 64'(ll_ready), 64'd1);
    step();
    pipe(5'd3, 64'h103); offer(5'd10, 64'hA0);
    #1;
    chk("full_rdy_full", 64'(ll_ready), 64'd0);
    step();
    chk_rf("full_p3", 1'b1, 5'd3, 64'h103);
    wb_valid = 0;
    #1;
    chk("full_rdy_held", 64'(ll_ready), 64'd0);
    step();
    chk_rf("full_x8", 1'b1, 5'd8, 64'h88);
    chk("full_rdy_after_pop", 64'(ll_ready), 64'd1);
    step();
    ll_valid = 0;
    chk_rf("full_x9", 1'b1, 5'd9, 64'h99);
    step();
    chk_rf("full_x10", 1'b1, 5'd10, 64'hA0);
    step();
    chk("full_drained", 64'(rf_we), 64'd0);

    // Scoreboard race: re-issue to x10 on the edge that pops x10.
    idle();
    ll_issue_valid = 1; ll_issue_rd = 5'd10;
    step();
    ll_issue_valid = 0;
    chk("race_pend_set", 64'(pend_mask), 64'h400);
    offer(5'd10, 64'h1010);
    step();
    ll_valid = 0;
    ll_issue_valid = 1; ll_issue_rd = 5'd10;
    step();
    ll_issue_valid = 0;
    chk_rf("race_pop", 1'b1, 5'd10, 64'h1010);
    chk("race_pend_kept", 64'(pend_mask), 64'h400);

    // Reset mid-operation with two buffered entries.
    do_reset();
    chk("rst2_pend", 64'(pend_mask), 64'h0);
    pipe(5'd1, 64'h201); offer(5'd8, 64'h8); ll_issue_valid = 1; ll_issue_rd = 5'd8;
    step();
    pipe(5'd2, 64'h202); offer(5'd9, 64'h9); ll_issue_rd = 5'd9;
    step();
    idle();
    wb_valid = 0;
    #1;
    chk("mid_pend", 64'(pend_mask), 64'h300);
    chk("mid_full", 64'(ll_ready), 64'd0);
    reset = 1;
    #1;
    chk("mid_rst_rdy", 64'(ll_ready), 64'd0);
    step();
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_rd", 64'(rf_rd), 64'd0);
    chk("mid_rst_wdata", rf_wdata, 64'd0);
    chk("mid_rst_pend", 64'(pend_mask), 64'd0);
    reset = 0;
    #1;
    chk("mid_post_rdy", 64'(ll_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mid_discard%0d", i), 64'(rf_we), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
